// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses the zero-latency instruction memory and
// holds one fetched instruction for decode behind a valid/ready handshake.
module instruction_fetch_unit #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0] PC_LIMIT = PC_WIDTH'(28)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [PC_WIDTH-1:0] imem_pc,
  input  logic [15:0]         imem_instr,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [15:0]         if_instr,
  output logic [PC_WIDTH-1:0] if_pc,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                halted,
  output logic [15:0]         fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc_p0;
  logic                vld_p1;
  logic [15:0]         instr_p1;
  logic [PC_WIDTH-1:0] pc_p1;
  logic                halted_r;
  logic [15:0]         count_r;

  // Redirect targets are forced onto a halfword boundary.
  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] a);
    return {a[PC_WIDTH-1:1], 1'b0};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic slot_free;
  assign slot_free = !vld_p1 || if_ready;

  // Stage p0 -> p1: PC addresses memory, returned word lands in the buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc_p0    <= RESET_PC;
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
      halted_r <= 1'b0;
      count_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) pc_p0 <= align_pc(redirect_pc);
          if (start)          state <= RUN;
        end
        RUN: begin
          if (redirect_valid) begin
            pc_p0  <= align_pc(redirect_pc);
            vld_p1 <= 1'b0;
          end else if (pc_p0 > PC_LIMIT) begin
            state    <= HALT;
            halted_r <= 1'b1;
            if (if_ready) vld_p1 <= 1'b0;
          end else if (slot_free) begin
            instr_p1 <= imem_instr;
            pc_p1    <= pc_p0;
            vld_p1   <= 1'b1;
            pc_p0    <= pc_p0 + PC_WIDTH'(2);
            count_r  <= sat_inc(count_r);
          end
        end
        HALT: begin
          if (redirect_valid) begin
            pc_p0    <= align_pc(redirect_pc);
            vld_p1   <= 1'b0;
            state    <= RUN;
            halted_r <= 1'b0;
          end else if (if_ready) begin
            vld_p1 <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_pc     = pc_p0;
  assign if_valid    = vld_p1;
  assign if_instr    = instr_p1;
  assign if_pc       = pc_p1;
  assign halted      = halted_r;
  assign fetch_count = count_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand-written
// halt/redirect sequence, then random traffic against a queue-based model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, start, if_ready, redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_pc, imem_instr, if_instr, if_pc, fetch_count;
  logic        if_valid, halted;

  logic [15:0] mem [16];
  assign imem_instr = mem[imem_pc[4:1]];

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .imem_pc(imem_pc),
    .imem_instr(imem_instr), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic rdy,
                       input logic rv, input logic [15:0] rp);
    reset = r; start = s; if_ready = rdy; redirect_valid = rv; redirect_pc = rp;
  endtask

  typedef struct {
    logic        rst, st, rdy, rv;
    logic [15:0] rp;
    logic        e_valid;
    logic [15:0] e_pc, e_instr, e_imem, e_cnt;
    logic        e_halt;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(input logic rst, st, rdy, rv, input logic [15:0] rp,
                              input logic ev, input logic [15:0] epc, ein, eim, ecnt,
                              input logic eh);
    vec_t v;
    v.rst = rst; v.st = st; v.rdy = rdy; v.rv = rv; v.rp = rp;
    v.e_valid = ev; v.e_pc = epc; v.e_instr = ein; v.e_imem = eim; v.e_cnt = ecnt;
    v.e_halt = eh;
    return v;
  endfunction

  // Reference model: mode 0=idle 1=run 2=halt, buffer kept as a queue
  typedef struct { logic [15:0] pc, instr; } ent_t;
  ent_t        m_q[$];
  int          m_mode;
  logic [15:0] m_pc;
  int          m_cnt;

  task automatic model_step(input logic r, s, rdy, rv, input logic [15:0] rp);
    bit consumed;
    ent_t e;
    if (r) begin
      m_mode = 0; m_pc = 16'h0000; m_cnt = 0; m_q.delete();
      return;
    end
    consumed = (m_q.size() != 0) && rdy;
    case (m_mode)
      0: begin
        if (rv) m_pc = rp & 16'hFFFE;
        if (s) m_mode = 1;
      end
      1: begin
        if (rv) begin
          m_pc = rp & 16'hFFFE;
          m_q.delete();
        end else if (m_pc > 16'd28) begin
          m_mode = 2;
          if (consumed) void'(m_q.pop_front());
        end else if (m_q.size() == 0 || consumed) begin
          if (consumed) void'(m_q.pop_front());
          e.pc = m_pc; e.instr = mem[m_pc[4:1]];
          m_q.push_back(e);
          m_pc = m_pc + 16'd2;
          m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        end
      end
      default: begin
        if (rv) begin
          m_pc = rp & 16'hFFFE;
          m_q.delete();
          m_mode = 1;
        end else if (consumed) void'(m_q.pop_front());
      end
    endcase
  endtask

  initial begin
    bit ok;
    logic r, s, rdy, rv;
    logic [15:0] rp;

    mem[0] = 16'h0400; mem[1] = 16'h0441; mem[2] = 16'h2050;
    for (int i = 3; i < 16; i++) mem[i] = 16'h3000 + 16'(i);

    //          rst st rdy rv rp       valid if_pc    if_instr  imem     cnt     halt
    vt[0]  = mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0, 0);
    vt[1]  = mk(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0, 0);
    vt[2]  = mk(0, 0, 1, 0, 16'h0000, 1, 16'h0000, 16'h0400, 16'h0002, 16'd1, 0);
    vt[3]  = mk(0, 0, 1, 0, 16'h0000, 1, 16'h0002, 16'h0441, 16'h0004, 16'd2, 0);
    vt[4]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'h0002, 16'h0441, 16'h0004, 16'd2, 0);
    vt[5]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'h0002, 16'h0441, 16'h0004, 16'd2, 0);
    vt[6]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'h0002, 16'h0441, 16'h0004, 16'd2, 0);
    vt[7]  = mk(0, 0, 1, 0, 16'h0000, 1, 16'h0004, 16'h2050, 16'h0006, 16'd3, 0);
    vt[8]  = mk(0, 0, 0, 1, 16'h0019, 0, 16'h0004, 16'h2050, 16'h0018, 16'd3, 0);
    vt[9]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'h0018, 16'h300C, 16'h001A, 16'd4, 0);
    vt[10] = mk(0, 0, 1, 1, 16'h0000, 0, 16'h0018, 16'h300C, 16'h0000, 16'd4, 0);
    vt[11] = mk(0, 0, 1, 0, 16'h0000, 1, 16'h0000, 16'h0400, 16'h0002, 16'd5, 0);
    vt[12] = mk(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0, 0);
    vt[13] = mk(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0, 0);
    vt[14] = mk(0, 0, 1, 1, 16'h000A, 0, 16'h0000, 16'h0000, 16'h000A, 16'd0, 0);
    vt[15] = mk(0, 1, 0, 1, 16'h0005, 0, 16'h0000, 16'h0000, 16'h0004, 16'd0, 0);
    vt[16] = mk(0, 0, 1, 0, 16'h0000, 1, 16'h0004, 16'h2050, 16'h0006, 16'd1, 0);

    drive(1, 0, 0, 0, 16'h0000);
    tick();
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rst, vt[i].st, vt[i].rdy, vt[i].rv, vt[i].rp);
      tick();
      chk($sformatf("v%0d.if_valid", i), 32'(if_valid), 32'(vt[i].e_valid));
      chk($sformatf("v%0d.if_pc", i), 32'(if_pc), 32'(vt[i].e_pc));
      chk($sformatf("v%0d.if_instr", i), 32'(if_instr), 32'(vt[i].e_instr));
      chk($sformatf("v%0d.imem_pc", i), 32'(imem_pc), 32'(vt[i].e_imem));
      chk($sformatf("v%0d.fetch_count", i), 32'(fetch_count), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d.halted", i), 32'(halted), 32'(vt[i].e_halt));
    end

    // Run off the end of the program, then leave HALT by redirecting to 0
    drive(1, 0, 0, 0, 16'h0000); tick();
    drive(0, 1, 1, 0, 16'h0000); tick();
    drive(0, 0, 1, 0, 16'h0000);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      tick();
      if (if_valid && if_pc == 16'd28) ok = 1'b1;
    end
    chk("end.reached_28", 32'(ok), 32'd1);
    chk("end.instr_28", 32'(if_instr), 32'(mem[14]));
    chk("end.halted_before", 32'(halted), 32'd0);
    tick();
    chk("end.halted", 32'(halted), 32'd1);
    chk("end.if_valid", 32'(if_valid), 32'd0);
    chk("end.fetch_count", 32'(fetch_count), 32'd15);
    drive(0, 1, 1, 0, 16'h0000); tick();
    chk("halt.start_ignored", 32'(halted), 32'd1);
    drive(0, 0, 1, 1, 16'h0000); tick();
    chk("halt.redir_halted", 32'(halted), 32'd0);
    chk("halt.redir_valid", 32'(if_valid), 32'd0);
    drive(0, 0, 1, 0, 16'h0000); tick();
    chk("halt.redir_if_pc", 32'(if_pc), 32'h0000);
    chk("halt.redir_instr", 32'(if_instr), 32'h0400);
    chk("halt.redir_valid2", 32'(if_valid), 32'd1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      r   = (c == 0) || ($urandom_range(0, 149) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rdy = $urandom_range(0, 1) == 1;
      rv  = ($urandom_range(0, 9) == 0);
      rp  = 16'($urandom_range(0, 40));
      drive(r, s, rdy, rv, rp);
      model_step(r, s, rdy, rv, rp);
      tick();
      chk($sformatf("rnd%0d.if_valid", c), 32'(if_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk($sformatf("rnd%0d.if_pc", c), 32'(if_pc), 32'(m_q[0].pc));
        chk($sformatf("rnd%0d.if_instr", c), 32'(if_instr), 32'(m_q[0].instr));
      end
      chk($sformatf("rnd%0d.imem_pc", c), 32'(imem_pc), 32'(m_pc));
      chk($sformatf("rnd%0d.fetch_count", c), 32'(fetch_count), 32'(m_cnt));
      chk($sformatf("rnd%0d.halted", c), 32'(halted), 32'(m_mode == 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
